// File: rtl/aes_inv_cipher_iter_if.sv
// Handshake and key-read bundle for the iterative AES inverse cipher.
// Signals: in_valid/in_ready/in_data, rk_idx/rk_data, out_valid/out_ready/out_data.
interface aes_inv_cipher_iter_if #(
    parameter int CNT_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [127:0]     in_data;
    logic [CNT_W-1:0] rk_idx;
    logic [127:0]     rk_data;
    logic             out_valid;
    logic             out_ready;
    logic [127:0]     out_data;

    modport master (
        output in_valid, in_data, rk_data, out_ready,
        input  in_ready, rk_idx, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, rk_data, out_ready,
        output in_ready, rk_idx, out_valid, out_data
    );
endinterface

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher: one inverse round per clock, NR+1 cycles per block.
// Ports: clk, rst (sync, active-high); bus (slave) carries ciphertext in,
// combinational round-key read (rk_idx -> rk_data) and plaintext out.
module aes_inv_cipher_iter #(
    parameter int NR    = 10,
    parameter int CNT_W = 4
) (
    input logic                  clk,
    input logic                  rst,
    aes_inv_cipher_iter_if.slave bus
);
    if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
        $error("aes_inv_cipher_iter: NR must be 10, 12 or 14");
    end
    if ((1 << CNT_W) <= NR) begin : g_bad_cnt
        $error("aes_inv_cipher_iter: CNT_W too narrow for NR");
    end

    localparam logic [CNT_W-1:0] IDX_NR   = CNT_W'(NR);
    localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(NR - 1);

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_e;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] x;
        r = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ x;
            x = xtime(x);
        end
        return r;
    endfunction

    // Inverse S-box: undo the affine map, then invert in GF(2^8) as t^254
    // (zero maps to zero for free).
    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        logic [7:0] t;
        logic [7:0] p;
        logic [7:0] r;
        t = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
        p = t;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    // Byte k = r + 4c lives at bits [127-8k -: 8]; row r rotates right by r.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int k = 0; k < 16; k++) begin
            o[127-8*k -: 8] = inv_sbox(s[127-8*k -: 8]);
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b)
                             ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e)
                             ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09)
                             ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d)
                             ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
        return o;
    endfunction

    state_e           fsm_q, fsm_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [127:0]     st_q, st_d;
    logic [127:0]     ark;

    // The final round is this same path without InvMixColumns.
    assign ark = inv_sub_bytes(inv_shift_rows(st_q)) ^ bus.rk_data;

    assign bus.out_valid = (fsm_q == DONE);
    assign bus.out_data  = st_q;

    always_comb begin
        fsm_d        = fsm_q;
        cnt_d        = cnt_q;
        st_d         = st_q;
        bus.in_ready = 1'b0;
        bus.rk_idx   = IDX_NR;
        unique case (fsm_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    st_d  = bus.in_data ^ bus.rk_data;
                    cnt_d = IDX_LAST;
                    fsm_d = ROUND;
                end
            end
            ROUND: begin
                bus.rk_idx = cnt_q;
                st_d       = inv_mix_columns(ark);
                cnt_d      = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) fsm_d = FINAL;
            end
            FINAL: begin
                bus.rk_idx = '0;
                st_d       = ark;
                fsm_d      = DONE;
            end
            DONE: begin
                bus.in_ready = bus.out_ready;
                if (bus.out_ready) begin
                    if (bus.in_valid) begin
                        st_d  = bus.in_data ^ bus.rk_data;
                        cnt_d = IDX_LAST;
                        fsm_d = ROUND;
                    end else begin
                        fsm_d = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q <= IDLE;
            cnt_q <= '0;
            st_q  <= '0;
        end else begin
            fsm_q <= fsm_d;
            cnt_q <= cnt_d;
            st_q  <= st_d;
        end
    end
endmodule

// File: doc/aes_inv_cipher_iter.md
Name: aes_inv_cipher_iter

Overview:
- Iterative AES inverse cipher. Runs a full decryption of one 128-bit block, one inverse round per clock, using externally stored expanded round keys.
- Generalises the single combinational inverse round to a parametrised round count (AES-128/192/256), a round counter and FSM, and valid/ready handshakes on both input and output.
- Sits between the key-schedule RAM (read port) and the decrypt datapath consumer.

Parameters:
- NR, 10, number of rounds. Legal values 10, 12 or 14; any other value is an elaboration error.
- CNT_W, 4, round-counter / rk_idx width. Must satisfy 2^CNT_W > NR.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  ciphertext valid.
- in_ready  output  1  block accepts a ciphertext this cycle.
- in_data  input  128  ciphertext. Bits [127:120] are byte 0 = s[0][0]; column-major per FIPS-197.
- rk_idx  output  CNT_W  round-key index requested, 0..NR.
- rk_data  input  128  round key rk_idx, combinational read (same cycle). Byte order as in_data.
- out_valid  output  1  plaintext valid.
- out_ready  input  1  consumer accepts plaintext.
- out_data  output  128  plaintext. Byte order as in_data.

Behaviour:
- Reset (rst=1 at a clk edge): FSM to IDLE, counter=0, state register=0, out_valid=0. in_ready=1 from the next cycle. Reset mid-operation discards the in-flight block; no out_valid pulse follows.
- FSM states:
  - IDLE: in_ready=1, rk_idx=NR. On in_valid&&in_ready: state <= in_data ^ rk_data, counter <= NR-1, go to ROUND.
  - ROUND: in_ready=0, rk_idx=counter.
    - If counter>=1: state <= InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), rk_data)), counter--.
    - When counter==1 is processed, next state is FINAL.
  - FINAL: rk_idx=0. state <= InvSubBytes(InvShiftRows(state)) ^ rk_data (no InvMixColumns), out_valid <= 1, go to DONE.
  - DONE: out_valid=1, out_data=state, held stable until out_ready. rk_idx=NR; in_ready=out_ready.
    - out_ready && !in_valid: out_valid <= 0, go to IDLE.
    - out_ready && in_valid: back-to-back. Load in_data ^ rk_data[NR], out_valid <= 0, go to ROUND.
    - !out_ready: no state change; in_valid is ignored.
- Latency: accept edge E0; out_valid high after edge E_NR, i.e. NR cycles after acceptance (10/12/14).
- Throughput with out_ready held high: one block per NR+1 cycles.
- out_data equals the state register at all times. It is valid only when out_valid=1.
- InvSubBytes uses 16 parallel inverse S-box lookups. InvMixColumns uses GF(2^8) mod x^8+x^4+x^3+x+1 with coefficients {0e,0b,0d,09}.
- InvShiftRows rotates row r right by r bytes.
- The block ignores in_valid whenever in_ready=0. rk_data is sampled only on state-updating edges.

Test Plan:
- FIPS-197 C.1, NR=10. Round keys expanded from 000102030405060708090a0b0c0d0e0f (rk[10]=13111d7fe3944a17f307a78b4d2b30c5); in_data=69c4e0d86a7b0430d8cdb78070b4c55a, out_ready=1 -> out_valid exactly 10 cycles after accept, out_data=00112233445566778899aabbccddeeff. rk_idx sequence 10,9,...,1,0.
- NR=12, C.2: key 000102...1617; in_data=dda97ca4864cdfe06eaf70a0ec0d7191 -> out_data=00112233445566778899aabbccddeeff after 12 cycles. NR=14, C.3: key 000102...1e1f; in_data=8ea2b7ca516745bfeafc49904b496089 -> same plaintext after 14 cycles.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_valid and out_data stable; in_ready=0; a pulsed in_valid is ignored; no second acceptance occurs.
- Back-to-back: in_valid held, out_ready=1, two C.1 ciphertexts -> the second is accepted on the same edge the first is consumed; outputs are 11 cycles apart; both equal the expected plaintext.
- Reset mid-operation: assert rst at round counter 4 for one cycle -> out_valid=0 next cycle, in_ready=1, rk_idx=NR. A subsequent C.1 decrypt is correct with normal latency.
- Idle stability: in_valid=0 for 20 cycles after reset -> out_valid=0, in_ready=1, rk_idx=NR throughout.
